// File: rtl/fetch_sequencer_pkg.sv
// Shared cycle encodings and request-priority decode for the instruction-fetch sequencer.
// Optional stack checking is selected with FETCH_STACK_CHECK_EN (see pc_stack).
package fetch_sequencer_pkg;

    localparam int unsigned CYCLE_W = 3;

    localparam logic [CYCLE_W-1:0] M1_IDX = 3'd3;
    localparam logic [CYCLE_W-1:0] M2_IDX = 3'd4;
    localparam logic [CYCLE_W-1:0] X1_IDX = 3'd5;
    localparam logic [CYCLE_W-1:0] X3_IDX = 3'd7;

    typedef enum logic [CYCLE_W-1:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = M1_IDX,
        CYC_M2 = M2_IDX,
        CYC_X1 = X1_IDX,
        CYC_X2 = 3'd6,
        CYC_X3 = X3_IDX
    } cycle_e;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_POP,
        REQ_CALL,
        REQ_JUMP,
        REQ_SHORT
    } req_e;

    // Return beats call; a push without a long jump is not a request at all.
    function automatic req_e req_decode(input logic pop, input logic load,
                                        input logic load_short, input logic push);
        if (pop)             return REQ_POP;
        if (load && push)    return REQ_CALL;
        if (load)            return REQ_JUMP;
        if (load_short)      return REQ_SHORT;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_stack.sv
// Return-address stack for the fetch sequencer. FETCH_STACK_CHECK_EN selects a bounded
// stack with sticky overflow/underflow flags; otherwise the stack is circular.
module pc_stack
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned STACK_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              push_en,
    input  logic              pop_en,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] pop_addr,
    output logic              pop_ok,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d, top;
    logic              wr_en;

`ifdef FETCH_STACK_CHECK_EN
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        pop_ok = (sp_q != '0);
        top    = pop_ok ? (sp_q - SP_W'(1)) : '0;
        if (pop_en) begin
            if (pop_ok) sp_d  = top;
            else        unf_d = 1'b1;
        end else if (push_en) begin
            if (sp_q == SP_FULL) begin
                ovf_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                sp_d  = sp_q + SP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    // Pointer stays in 0..STACK_DEPTH-1 and wraps both ways, so overflow overwrites the oldest entry.
    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        pop_ok = 1'b1;
        top    = (sp_q == '0) ? SP_W'(STACK_DEPTH - 1) : (sp_q - SP_W'(1));
        if (pop_en) begin
            sp_d = top;
        end else if (push_en) begin
            wr_en = 1'b1;
            sp_d  = (sp_q == SP_W'(STACK_DEPTH - 1)) ? '0 : (sp_q + SP_W'(1));
        end
    end

    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    always_comb begin
        stack_d = stack_q;
        if (wr_en) stack_d[IDX_W'(sp_q)] = push_addr;
    end

    assign pop_addr = stack_q[IDX_W'(top)];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sp_q <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            sp_q    <= sp_d;
            stack_q <= stack_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: 8-state machine cycle, OPR/OPA latches, PC and call stack.
// Define FETCH_STACK_CHECK_EN for a bounded stack with sticky overflow/underflow flags.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned PAGE_W      = 8,
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned STACK_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [DATA_W-1:0] romData,
    input  logic              pcLoad,
    input  logic              pcLoadShort,
    input  logic              pushReq,
    input  logic              popReq,
    input  logic [ADDR_W-1:0] pcNew,
    output logic [2:0]        cycle,
    output logic              sync,
    output logic [ADDR_W-1:0] pcAddr,
    output logic [DATA_W-1:0] opr,
    output logic [DATA_W-1:0] opa,
    output logic              instrValid,
    output logic              stackOvf,
    output logic              stackUnf
);

    cycle_e            cycle_q, cycle_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pop_addr;
    logic [DATA_W-1:0] opr_q, opr_d, opa_q, opa_d;
    logic              push_en, pop_en, pop_ok;
    req_e              req;

    always_comb begin
        cycle_d = (cycle_q == CYC_X3) ? CYC_A1 : cycle_e'(cycle_q + 3'd1);
        opr_d   = opr_q;
        opa_d   = opa_q;
        pc_d    = pc_q;
        req     = REQ_NONE;
        push_en = 1'b0;
        pop_en  = 1'b0;

        if (cycle_q == CYC_M1) opr_d = romData;
        if (cycle_q == CYC_M2) begin
            opa_d = romData;
            pc_d  = pc_q + ADDR_W'(1);
        end

        // By X3 pc_q already holds PC+1: it is both the return address and the short-jump page.
        if (cycle_q == CYC_X3) begin
            req = req_decode(popReq, pcLoad, pcLoadShort, pushReq);
            case (req)
                REQ_POP: begin
                    pop_en = 1'b1;
                    if (pop_ok) pc_d = pop_addr;
                end
                REQ_CALL: begin
                    push_en = 1'b1;
                    pc_d    = pcNew;
                end
                REQ_JUMP:  pc_d = pcNew;
                REQ_SHORT: pc_d = {pc_q[ADDR_W-1:PAGE_W], pcNew[PAGE_W-1:0]};
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cycle_q <= CYC_A1;
            pc_q    <= '0;
            opr_q   <= '0;
            opa_q   <= '0;
        end else begin
            cycle_q <= cycle_d;
            pc_q    <= pc_d;
            opr_q   <= opr_d;
            opa_q   <= opa_d;
        end
    end

    pc_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_pc_stack (
        .clk       (clk),
        .rstN      (rstN),
        .push_en   (push_en),
        .pop_en    (pop_en),
        .push_addr (pc_q),
        .pop_addr  (pop_addr),
        .pop_ok    (pop_ok),
        .stack_ovf (stackOvf),
        .stack_unf (stackUnf)
    );

    assign cycle      = cycle_q;
    assign sync       = (cycle_q == CYC_X3);
    assign instrValid = (cycle_q == CYC_X1);
    assign pcAddr     = pc_q;
    assign opr        = opr_q;
    assign opa        = opa_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, nested-call and reset
// sequences, then randomized instructions against an instruction-level reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned PAGE_W = 8;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 3;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic [DATA_W-1:0] romData = '0;
    logic              pcLoad = 1'b0, pcLoadShort = 1'b0, pushReq = 1'b0, popReq = 1'b0;
    logic [ADDR_W-1:0] pcNew = '0;
    logic [2:0]        cycle;
    logic              sync, instrValid, stackOvf, stackUnf;
    logic [ADDR_W-1:0] pcAddr;
    logic [DATA_W-1:0] opr, opa;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W      (ADDR_W),
        .PAGE_W      (PAGE_W),
        .DATA_W      (DATA_W),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .romData     (romData),
        .pcLoad      (pcLoad),
        .pcLoadShort (pcLoadShort),
        .pushReq     (pushReq),
        .popReq      (popReq),
        .pcNew       (pcNew),
        .cycle       (cycle),
        .sync        (sync),
        .pcAddr      (pcAddr),
        .opr         (opr),
        .opa         (opa),
        .instrValid  (instrValid),
        .stackOvf    (stackOvf),
        .stackUnf    (stackUnf)
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one call per fetched instruction, straight from the request rules.
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_stack [DEPTH];
    int                m_sp;
    logic              m_ovf, m_unf;

    task automatic model_reset();
        m_pc  = '0;
        m_sp  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_stack[i] = '0;
    endtask

    task automatic model_instr(input logic pop, input logic load, input logic sh,
                               input logic push, input logic [ADDR_W-1:0] npc);
        logic [ADDR_W-1:0] ret;
        ret  = m_pc + 12'd1;
        m_pc = ret;
        if (pop) begin
`ifdef FETCH_STACK_CHECK_EN
            if (m_sp == 0) m_unf = 1'b1;
            else begin
                m_sp = m_sp - 1;
                m_pc = m_stack[m_sp];
            end
`else
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            m_pc = m_stack[m_sp];
`endif
        end else if (load) begin
            if (push) begin
`ifdef FETCH_STACK_CHECK_EN
                if (m_sp == DEPTH) m_ovf = 1'b1;
                else begin
                    m_stack[m_sp] = ret;
                    m_sp = m_sp + 1;
                end
`else
                m_stack[m_sp] = ret;
                m_sp = (m_sp + 1) % DEPTH;
`endif
            end
            m_pc = npc;
        end else if (sh) begin
            m_pc = {ret[ADDR_W-1:PAGE_W], npc[PAGE_W-1:0]};
        end
    endtask

    // Runs one full instruction starting at a negedge in A1; noise: 0 quiet, 1 random
    // requests outside X3, 2 a pcLoad to 0x3F0 in cycle 2 only.
    task automatic do_instr(input logic [DATA_W-1:0] o_r, input logic [DATA_W-1:0] o_a,
                            input logic pop, input logic load, input logic sh, input logic push,
                            input logic [ADDR_W-1:0] npc, input int noise);
        logic [ADDR_W-1:0] pc0, pc1;
        pc0 = m_pc;
        pc1 = m_pc + 12'd1;
        for (int k = 0; k < 8; k++) begin
            chk("cycle", cycle, k);
            chk("sync", sync, (k == 7));
            chk("instrValid", instrValid, (k == 5));
            chk("pcAddr", pcAddr, (k <= 4) ? pc0 : pc1);
            if (k >= 4) chk("opr", opr, o_r);
            if (k >= 5) chk("opa", opa, o_a);
            romData = (k == 3) ? o_r : (k == 4) ? o_a : 4'($urandom);
            if (k == 7) begin
                {popReq, pcLoad, pcLoadShort, pushReq} = {pop, load, sh, push};
                pcNew = npc;
            end else if (noise == 1) begin
                {popReq, pcLoad, pcLoadShort, pushReq} = 4'($urandom);
                pcNew = 12'($urandom);
            end else begin
                {popReq, pcLoadShort, pushReq} = 3'b000;
                pcLoad = (noise == 2) && (k == 2);
                pcNew  = (noise == 2) ? 12'h3F0 : 12'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end
        {popReq, pcLoad, pcLoadShort, pushReq} = 4'b0000;
        model_instr(pop, load, sh, push, npc);
        chk("model_pc", pcAddr, m_pc);
        chk("stackOvf", stackOvf, m_ovf);
        chk("stackUnf", stackUnf, m_unf);
    endtask

    typedef struct {
        logic [DATA_W-1:0] o_r;
        logic [DATA_W-1:0] o_a;
        logic              pop;
        logic              load;
        logic              sh;
        logic              push;
        logic [ADDR_W-1:0] npc;
        logic [ADDR_W-1:0] exp_pc;
        logic              exp_ovf;
        logic              exp_unf;
    } vec_t;

    vec_t vecs [11];
    vec_t nest [8];

    initial begin
        // Directed vectors: {opr, opa, pop, load, short, push, pcNew, next PC, ovf, unf}
        vecs[0]  = '{4'hA, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b0, 1'b0};
        vecs[1]  = '{4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 12'h3F0, 12'h3F0, 1'b0, 1'b0};
        vecs[2]  = '{4'h3, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 12'h020, 12'h020, 1'b0, 1'b0};
        vecs[3]  = '{4'h5, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 12'h100, 12'h100, 1'b0, 1'b0};
        vecs[4]  = '{4'h7, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 12'h555, 12'h021, 1'b0, 1'b0};
        vecs[5]  = '{4'h9, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 12'h2FF, 12'h2FF, 1'b0, 1'b0};
        vecs[6]  = '{4'hC, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012, 12'h312, 1'b0, 1'b0};
        vecs[7]  = '{4'hE, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777, 12'h313, 1'b0, 1'b0};
        vecs[8]  = '{4'h0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFAB, 12'h3AB, 1'b0, 1'b0};
        vecs[9]  = '{4'h2, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFFF, 12'hFFF, 1'b0, 1'b0};
        vecs[10] = '{4'h4, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0};

        // Four nested calls from 0x001, then four returns.
`ifdef FETCH_STACK_CHECK_EN
        nest[0] = '{4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h400, 12'h400, 1'b0, 1'b0};
        nest[1] = '{4'h2, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h500, 12'h500, 1'b0, 1'b0};
        nest[2] = '{4'h2, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 12'h600, 12'h600, 1'b0, 1'b0};
        nest[3] = '{4'h2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 12'h700, 12'h700, 1'b1, 1'b0};
        nest[4] = '{4'hC, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h501, 1'b1, 1'b0};
        nest[5] = '{4'hC, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h401, 1'b1, 1'b0};
        nest[6] = '{4'hC, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h002, 1'b1, 1'b0};
        nest[7] = '{4'hC, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h003, 1'b1, 1'b1};
`else
        nest[0] = '{4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h400, 12'h400, 1'b0, 1'b0};
        nest[1] = '{4'h2, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h500, 12'h500, 1'b0, 1'b0};
        nest[2] = '{4'h2, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 12'h600, 12'h600, 1'b0, 1'b0};
        nest[3] = '{4'h2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 12'h700, 12'h700, 1'b0, 1'b0};
        nest[4] = '{4'hC, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h601, 1'b0, 1'b0};
        nest[5] = '{4'hC, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h501, 1'b0, 1'b0};
        nest[6] = '{4'hC, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h401, 1'b0, 1'b0};
        nest[7] = '{4'hC, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h601, 1'b0, 1'b0};
`endif

        model_reset();
        #2;
        chk("rst_cycle", cycle, 0);
        chk("rst_pcAddr", pcAddr, 0);
        chk("rst_opr", opr, 0);
        chk("rst_opa", opa, 0);
        chk("rst_instrValid", instrValid, 0);
        chk("rst_sync", sync, 0);
        chk("rst_stackOvf", stackOvf, 0);
        chk("rst_stackUnf", stackUnf, 0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_instr(vecs[i].o_r, vecs[i].o_a, vecs[i].pop, vecs[i].load, vecs[i].sh,
                     vecs[i].push, vecs[i].npc, 0);
            chk("tbl_pc", pcAddr, vecs[i].exp_pc);
        end

        // pcLoad raised only in cycle 2 must not redirect the fetch.
        do_instr(4'h6, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2);
        chk("cyc2_ignored_pc", pcAddr, 12'h001);

        for (int i = 0; i < 8; i++) begin
            do_instr(nest[i].o_r, nest[i].o_a, nest[i].pop, nest[i].load, nest[i].sh,
                     nest[i].push, nest[i].npc, 0);
            chk("nest_pc", pcAddr, nest[i].exp_pc);
            chk("nest_ovf", stackOvf, nest[i].exp_ovf);
            chk("nest_unf", stackUnf, nest[i].exp_unf);
        end

        // Asynchronous reset asserted in the middle of M2.
        for (int k = 0; k < 4; k++) begin
            romData = (k == 3) ? 4'hC : 4'h0;
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_cycle", cycle, 4);
        chk("pre_rst_opr", opr, 4'hC);
        #2 rstN = 1'b0;
        #1;
        chk("async_cycle", cycle, 0);
        chk("async_pcAddr", pcAddr, 0);
        chk("async_opr", opr, 0);
        chk("async_opa", opa, 0);
        chk("async_stackOvf", stackOvf, 0);
        chk("async_stackUnf", stackUnf, 0);
        @(negedge clk);
        rstN = 1'b1;
        model_reset();
        do_instr(4'hA, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0);
        chk("post_rst_pc", pcAddr, 12'h001);

        for (int i = 0; i < 150; i++) begin
            do_instr(4'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 1) == 0), 12'($urandom), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
